w_stage_writeback: RTL

//  Write-back stage and GPR file of the 5-stage MIPS pipeline; the consumer side of the M/W pipeline register.

---
 rtl/w_stage_writeback_pkg.sv | 44 ++++
 rtl/w_stage_writeback_load_ext.sv | 35 +++
 rtl/w_stage_writeback.sv | 125 ++++++++++++
 3 files changed

// File: rtl/w_stage_writeback_pkg.sv
// MIPS ISA constants shared by the pipeline stages, plus write-back select/load types.
// Latency: n/a (package only).
// Backpressure: n/a.
package w_stage_writeback_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes that matter to write-back
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;

  // Link register
  localparam logic [4:0] RA = 5'd31;

  typedef enum logic [2:0] {LD_W, LD_B, LD_BU, LD_H, LD_HU} ld_op_t;
  typedef enum logic [1:0] {SEL_AO, SEL_PC8, SEL_LD} wb_sel_t;

  // SPECIAL functs that write an ALU result to rd (shifts, add/sub, logic, set-less-than)
  function automatic logic is_r_alu(input logic [5:0] fn);
    return fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                      6'h2a, 6'h2b};
  endfunction

  // Immediate ALU ops, addi..lui, all write rt
  function automatic logic is_i_alu(input logic [5:0] op);
    return (op >= OP_ADDI) && (op <= OP_LUI);
  endfunction

endpackage

// File: rtl/w_stage_writeback_load_ext.sv
// Load extender: picks byte/half/word out of the DM word and sign/zero extends it.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module wb_load_ext
  import w_stage_writeback_pkg::*;
(
  input  ld_op_t      op,
  input  logic [1:0]  off,
  input  logic [31:0] dr_w,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select by offset, then extension by load type
  always_comb begin
    byte_sel = dr_w[7:0];
    case (off)
      2'd1:    byte_sel = dr_w[15:8];
      2'd2:    byte_sel = dr_w[23:16];
      2'd3:    byte_sel = dr_w[31:24];
      default: byte_sel = dr_w[7:0];
    endcase
    half_sel = off[1] ? dr_w[31:16] : dr_w[15:0];
    case (op)
      LD_B:    ext = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   ext = {24'h0, byte_sel};
      LD_H:    ext = {{16{half_sel[15]}}, half_sel};
      LD_HU:   ext = {16'h0, half_sel};
      default: ext = dr_w;
    endcase
  end

endmodule

// File: rtl/w_stage_writeback.sv
// W stage: decodes IR_W, commits the write-back value to the 32x32 GPR file, bypasses W->D reads.
// Latency: reads and WA/WD/WE are combinational; GPR and RETIRED update on the next rising edge.
// Backpressure: none; one instruction leaves W every cycle, bubbles are IR_W == 0.
module w_stage_writeback
  import w_stage_writeback_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int TRACE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_W,
  input  logic [31:0]      PC_W,
  input  logic [31:0]      PC8_W,
  input  logic [31:0]      AO_W,
  input  logic [31:0]      DR_W,
  input  logic [4:0]       A1_D,
  input  logic [4:0]       A2_D,
  output logic [31:0]      RD1_D,
  output logic [31:0]      RD2_D,
  output logic [4:0]       WA_W,
  output logic [31:0]      WD_W,
  output logic             WE_W,
  output logic [CNT_W-1:0] RETIRED
);

  logic [5:0]       op, fn;
  logic [4:0]       rt, rd, dst;
  wb_sel_t          sel;
  ld_op_t           ld_op;
  logic [31:0]      ld_data;
  logic             ir_vld;
  logic [31:0]      gpr_q [32];
  logic [31:0]      gpr_d [32];
  logic [CNT_W-1:0] retired_q, retired_d;

  assign op     = IR_W[31:26];
  assign rt     = IR_W[20:16];
  assign rd     = IR_W[15:11];
  assign fn     = IR_W[5:0];
  assign ir_vld = (IR_W != 32'h0);

  // Destination, data source and load type from opcode/funct; unknown encodings write nothing
  always_comb begin
    dst   = 5'd0;
    sel   = SEL_AO;
    ld_op = LD_W;
    case (op)
      OP_SPECIAL: begin
        if (is_r_alu(fn) || fn == FN_MFHI || fn == FN_MFLO) begin
          dst = rd;
        end else if (fn == FN_JALR) begin
          dst = rd;
          sel = SEL_PC8;
        end
      end
      OP_JAL: begin dst = RA; sel = SEL_PC8; end
      OP_LB:  begin dst = rt; sel = SEL_LD; ld_op = LD_B;  end
      OP_LBU: begin dst = rt; sel = SEL_LD; ld_op = LD_BU; end
      OP_LH:  begin dst = rt; sel = SEL_LD; ld_op = LD_H;  end
      OP_LHU: begin dst = rt; sel = SEL_LD; ld_op = LD_HU; end
      OP_LW:  begin dst = rt; sel = SEL_LD; ld_op = LD_W;  end
      default: begin
        if (is_i_alu(op)) dst = rt;
      end
    endcase
  end

  wb_load_ext u_load_ext (
    .op   (ld_op),
    .off  (AO_W[1:0]),
    .dr_w (DR_W),
    .ext  (ld_data)
  );

  // Write-back data mux; $0 destinations never assert the enable
  always_comb begin
    case (sel)
      SEL_PC8: WD_W = PC8_W;
      SEL_LD:  WD_W = ld_data;
      default: WD_W = AO_W;
    endcase
    WA_W = dst;
    WE_W = (dst != 5'd0);
  end

  // Read ports: $0 is hard zero, an in-flight W write wins over the array
  always_comb begin
    if (A1_D == 5'd0)                RD1_D = 32'h0;
    else if (WE_W && A1_D == WA_W)   RD1_D = WD_W;
    else                             RD1_D = gpr_q[A1_D];
    if (A2_D == 5'd0)                RD2_D = 32'h0;
    else if (WE_W && A2_D == WA_W)   RD2_D = WD_W;
    else                             RD2_D = gpr_q[A2_D];
  end

  // Next register-file contents and retired count
  always_comb begin
    gpr_d = gpr_q;
    if (WE_W) gpr_d[WA_W] = WD_W;
    retired_d = retired_q + {{(CNT_W-1){1'b0}}, ir_vld};
  end

  // State registers; reset clears every GPR and the counter and blocks a coincident commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= 32'h0;
      retired_q <= '0;
    end else begin
      gpr_q     <= gpr_d;
      retired_q <= retired_d;
    end
  end

  assign RETIRED = retired_q;

`ifndef SYNTHESIS
  // Commit trace for simulation: one line per real register write
  always @(posedge clk) begin
    if (TRACE != 0 && !reset && WE_W)
      $display("%d@%h: $%d <= %h", $time, PC_W, WA_W, WD_W);
  end
`endif

endmodule
